// File: rtl/hopfield_spike_decoder.sv
// Hopfield recall readout: counts rising spike edges per neuron over a fixed window,
// thresholds them into a recalled pattern and reports the strongest neuron on valid/ready.
module hopfield_spike_decoder #(
    parameter int unsigned N      = 7,
    parameter int unsigned P      = 4,
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CW     = 8,
    parameter int unsigned THRESH = 4,
    parameter int unsigned IW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  spikes,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [P-1:0]  pattern_out,
    output logic [N-1:0]  active_mask,
    output logic [IW-1:0] winner_idx
);

    localparam int unsigned TW = $clog2(WINDOW);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] THR     = CW'(THRESH);
    localparam logic [TW-1:0] T_LAST  = TW'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DECIDE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    spikes_q;
    logic [N-1:0]    edges;
    logic [CW-1:0]   count [N];
    logic [TW-1:0]   timer;
    logic [N-1:0]    mask_c;
    logic [IW-1:0]   winner_c;
    logic [CW-1:0]   best_c;

    assign edges = spikes & ~spikes_q;

    // Next-state logic; start is only looked at in IDLE, so it is never queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COUNT;
            COUNT:   if (timer == T_LAST) state_next = DECIDE;
            DECIDE:  state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Threshold compare and first-maximum scan; an all-zero window leaves the index at N.
    always_comb begin
        best_c   = '0;
        winner_c = IW'(N);
        mask_c   = '0;
        for (int n = 0; n < int'(N); n++) begin
            mask_c[n] = (count[n] >= THR);
            if (count[n] > best_c) begin
                best_c   = count[n];
                winner_c = IW'(n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            spikes_q    <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            pattern_out <= '0;
            active_mask <= '0;
            winner_idx  <= '0;
            for (int n = 0; n < int'(N); n++) count[n] <= '0;
        end else begin
            state     <= state_next;
            spikes_q  <= spikes;
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == HOLD);
            case (state)
                IDLE: begin
                    if (start) begin
                        timer <= '0;
                        for (int n = 0; n < int'(N); n++) count[n] <= '0;
                    end
                end
                COUNT: begin
                    timer <= timer + TW'(1);
                    for (int n = 0; n < int'(N); n++) begin
                        if (edges[n] && (count[n] != CNT_MAX)) count[n] <= count[n] + CW'(1);
                    end
                end
                DECIDE: begin
                    pattern_out <= mask_c[P-1:0];
                    active_mask <= mask_c;
                    winner_idx  <= winner_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hopfield_spike_decoder.sv
// Self-checking bench: two decoder configurations share one stimulus stream and are
// compared against an edge-counting reference model built from the recorded spike trains.
module tb_hopfield_spike_decoder;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] spikes = '0;

    logic       busy_a, valid_a, busy_b, valid_b;
    logic [3:0] pat_a, pat_b;
    logic [6:0] mask_a, mask_b;
    logic [2:0] win_a, win_b;

    hopfield_spike_decoder #(.N(7), .P(4), .WINDOW(W), .CW(8), .THRESH(3)) dut_a (
        .clk(clk), .reset(reset), .start(start), .spikes(spikes),
        .busy(busy_a), .out_valid(valid_a), .out_ready(out_ready),
        .pattern_out(pat_a), .active_mask(mask_a), .winner_idx(win_a)
    );

    hopfield_spike_decoder #(.N(7), .P(4), .WINDOW(W), .CW(3), .THRESH(7)) dut_b (
        .clk(clk), .reset(reset), .start(start), .spikes(spikes),
        .busy(busy_b), .out_valid(valid_b), .out_ready(out_ready),
        .pattern_out(pat_b), .active_mask(mask_b), .winner_idx(win_b)
    );

    logic [6:0] seq [W];
    logic [6:0] pre;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count 0->1 transitions of the recorded trains, saturate, threshold, pick first maximum.
    function automatic void model(input int cw, input int th,
                                  output logic [6:0] mask, output logic [2:0] win);
        int cnt [7];
        int top;
        logic p;
        top = 0;
        for (int n = 0; n < 7; n++) begin
            cnt[n] = 0;
            for (int k = 0; k < int'(W); k++) begin
                if (k == 0) p = pre[n];
                else        p = seq[k-1][n];
                if (seq[k][n] && !p) cnt[n]++;
            end
            if (cnt[n] > (1 << cw) - 1) cnt[n] = (1 << cw) - 1;
            if (cnt[n] > top) top = cnt[n];
            mask[n] = (cnt[n] >= th);
        end
        win = 3'd7;
        if (top > 0) begin
            for (int n = 6; n >= 0; n--) if (cnt[n] == top) win = 3'(n);
        end
    endfunction

    task automatic chk_results(input string tag);
        logic [6:0] ma, mb;
        logic [2:0] wa, wb;
        model(8, 3, ma, wa);
        model(3, 7, mb, wb);
        chk({tag, "_pat_a"},  32'(pat_a),  32'(ma[3:0]));
        chk({tag, "_mask_a"}, 32'(mask_a), 32'(ma));
        chk({tag, "_win_a"},  32'(win_a),  32'(wa));
        chk({tag, "_pat_b"},  32'(pat_b),  32'(mb[3:0]));
        chk({tag, "_mask_b"}, 32'(mask_b), 32'(mb));
        chk({tag, "_win_b"},  32'(win_b),  32'(wb));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, 32'({busy_a, valid_a, pat_a, mask_a, win_a}), 32'(0));
        chk({tag, "_b"}, 32'({busy_b, valid_b, pat_b, mask_b, win_b}), 32'(0));
    endtask

    task automatic clear_seq;
        for (int k = 0; k < int'(W); k++) seq[k] = '0;
    endtask

    // start at cycle t, window t+1..t+W, result at t+W+2, then optional backpressure and handshake.
    task automatic run_window(input string tag, input bit early);
        spikes    = pre;
        start     = 1'b1;
        out_ready = early;
        tick();
        start = 1'b0;
        chk({tag, "_busy_start"}, 32'({busy_a, busy_b}), 32'(2'b11));
        for (int k = 0; k < int'(W); k++) begin
            spikes = seq[k];
            tick();
            chk({tag, "_valid_early"}, 32'({valid_a, valid_b}), 32'(0));
        end
        spikes = 7'($urandom) | 7'h01;
        tick();
        chk({tag, "_valid_rise"}, 32'({valid_a, valid_b}), 32'(2'b11));
        chk_results({tag, "_hold"});
        if (!early) begin
            out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                spikes = 7'($urandom);
                start  = (i == 3);
                tick();
                chk({tag, "_bp_valid"}, 32'({valid_a, valid_b}), 32'(2'b11));
                chk({tag, "_bp_busy"},  32'({busy_a, busy_b}),   32'(2'b11));
                chk_results({tag, "_bp"});
            end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        spikes    = 7'($urandom);
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'({valid_a, valid_b}), 32'(0));
        chk({tag, "_hs_busy"},  32'({busy_a, busy_b}),   32'(0));
        chk_results({tag, "_kept"});
    endtask

    task automatic random_trains;
        pre = 7'($urandom);
        for (int k = 0; k < int'(W); k++) seq[k] = 7'($urandom & $urandom);
    endtask

    initial begin
        // Reset with activity on the spike lines, then a long quiet idle.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            spikes = 7'($urandom);
            tick();
        end
        chk_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            spikes = 7'($urandom);
            tick();
            if (i % 10 == 9) chk_zero("idle");
        end

        // Basic decode: n0 x4, n2 x3, n3 x2, n5 x6.
        clear_seq();
        pre = '0;
        for (int i = 0; i < 4; i++) seq[2*i][0] = 1'b1;
        for (int i = 0; i < 3; i++) seq[2*i+1][2] = 1'b1;
        for (int i = 0; i < 2; i++) seq[2*i+8][3] = 1'b1;
        for (int i = 0; i < 6; i++) seq[2*i+1][5] = 1'b1;
        run_window("basic", 1'b0);
        chk("basic_pat_const",  32'(pat_a),  32'(4'b0101));
        chk("basic_mask_const", 32'(mask_a), 32'(7'b0100101));
        chk("basic_win_const",  32'(win_a),  32'(3'd5));

        // Edge semantics: n1 held high, n4 high before start, n0 pulse just before the window.
        clear_seq();
        pre = 7'b0010001;
        for (int k = 0; k < int'(W); k++) seq[k][1] = 1'b1;
        seq[0][4] = 1'b1;
        seq[3][4] = 1'b1;
        seq[6][4] = 1'b1;
        run_window("edge", 1'b1);
        chk("edge_mask_const", 32'(mask_a), 32'(0));
        chk("edge_win_const",  32'(win_a),  32'(3'd4));

        // Tie between n1 and n4 resolves to the lower index.
        clear_seq();
        pre = '0;
        for (int i = 0; i < 5; i++) begin
            seq[2*i][1] = 1'b1;
            seq[2*i][4] = 1'b1;
        end
        run_window("tie", 1'b0);
        chk("tie_win_const",  32'(win_a),  32'(3'd1));
        chk("tie_mask_const", 32'(mask_a), 32'(7'b0010010));

        // Empty window.
        clear_seq();
        pre = 7'($urandom);
        run_window("empty", 1'b1);
        chk("empty_win_const", 32'({win_a, win_b}),   32'(6'o77));
        chk("empty_pat_const", 32'({pat_a, mask_a}),  32'(0));

        // Saturation of the 3-bit counters at 7.
        clear_seq();
        pre = '0;
        for (int i = 0; i < 8; i++) seq[2*i][6] = 1'b1;
        run_window("sat", 1'b0);
        chk("sat_mask_b_const", 32'(mask_b), 32'(7'b1000000));
        chk("sat_win_b_const",  32'(win_b),  32'(3'd6));

        for (int r = 0; r < 6; r++) begin
            random_trains();
            run_window("rand", r[0]);
        end

        // Reset in the middle of a window, then a clean window from zero counts.
        spikes = '0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            spikes = 7'($urandom);
            tick();
        end
        reset = 1'b1;
        tick();
        chk_zero("midreset");
        reset = 1'b0;
        random_trains();
        run_window("after_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
